// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline sequencer.
//   pipe_state_e : which control case the pipeline is in this cycle
//   NOP_INSN     : instruction encoding the pipeline registers load as a NOP
//   is_stall()   : true for the cases in which the PC does not advance
package pipe_pkg;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    FREEZE     = 3'd1,
    REDIRECT   = 3'd2,
    HAZARD     = 3'd3,
    FETCH_WAIT = 3'd4
  } pipe_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h00000013;

  function automatic logic is_stall(input pipe_state_e s);
    return (s == FREEZE) || (s == HAZARD) || (s == FETCH_WAIT);
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf_counter.sv
// perf_counter: free-running event counter that wraps modulo 2^W.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   en    : count this cycle
//   count : current value
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline sequencer for the 5-stage core.
// Merges the ID hazard stall, the EX taken branch and the memory wait signals
// into load-enable / flush / bubble controls for PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB. Holds a taken branch that arrives while the pipeline is frozen, runs
// a hazard-stall watchdog and three performance counters.
//   Inputs : clk, rst (async, active high), hz_stall, br_taken, imem_wait,
//            dmem_wait
//   Outputs: pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
//            memwb_en (combinational), redirect_pend, hz_timeout (registered),
//            perf_cycles, perf_stalls, perf_flushes (registered counters)
// Handshake note: there is no valid/ready pairing here; every stage register
// loads when its enable is 1 at the rising edge and holds otherwise. A flush or
// bubble only has effect together with that stage's enable.
// The current control case is visible as the internal signal `mode` for
// checkers bound to this module.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_stall,
  input  logic             br_taken,
  input  logic             imem_wait,
  input  logic             dmem_wait,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             redirect_pend,
  output logic             hz_timeout,
  output logic [CNT_W-1:0] perf_cycles,
  output logic [CNT_W-1:0] perf_stalls,
  output logic [CNT_W-1:0] perf_flushes
);

  localparam int WD_W = $clog2(MAX_STALL + 2);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_STALL + 1);

  pipe_state_e     mode;
  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_cnt_next;
  logic            redirect_pend_next;
  logic            hz_timeout_next;
  logic            redir;

  // A held redirect counts exactly like a fresh one, so a br_taken that
  // repeats in the first unfrozen cycle is still a single redirect.
  assign redir = br_taken | redirect_pend;

  // ---------------------------------------------------------------------------
  // State register: held redirect, watchdog counter, sticky timeout
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pend <= 1'b0;
      wd_cnt        <= '0;
      hz_timeout    <= 1'b0;
    end else begin
      redirect_pend <= redirect_pend_next;
      wd_cnt        <= wd_cnt_next;
      hz_timeout    <= hz_timeout_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Case selection, control outputs and next state
  // ---------------------------------------------------------------------------
  always_comb begin
    mode               = RUN;
    pc_en              = 1'b1;
    ifid_en            = 1'b1;
    ifid_flush         = 1'b0;
    idex_en            = 1'b1;
    idex_bubble        = 1'b0;
    exmem_en           = 1'b1;
    memwb_en           = 1'b1;
    redirect_pend_next = redirect_pend;
    wd_cnt_next        = '0;
    hz_timeout_next    = hz_timeout;

    if (dmem_wait) begin
      mode = FREEZE;
    end else if (redir) begin
      mode = REDIRECT;
    end else if (hz_stall) begin
      mode = HAZARD;
    end else if (imem_wait) begin
      mode = FETCH_WAIT;
    end

    case (mode)
      FREEZE: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        // EX holds the branch target while frozen; remember that it was taken.
        if (br_taken) begin
          redirect_pend_next = 1'b1;
        end
        wd_cnt_next = wd_cnt;
      end
      REDIRECT: begin
        // Wrong-path instructions in IF and ID are squashed, so hazards and
        // fetch waits on them are irrelevant.
        ifid_flush         = 1'b1;
        idex_bubble        = 1'b1;
        redirect_pend_next = 1'b0;
      end
      HAZARD: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        // Saturate at the limit so a long stall cannot wrap the counter.
        wd_cnt_next = (wd_cnt == WD_LIMIT) ? wd_cnt : wd_cnt + 1'b1;
        if (wd_cnt_next == WD_LIMIT) begin
          hz_timeout_next = 1'b1;
        end
      end
      FETCH_WAIT: begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
      default: begin
      end
    endcase

    // While reset is held every stage stays loaded with NOPs.
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_en     = 1'b0;
      idex_bubble = 1'b1;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  perf_counter #(.W(CNT_W)) u_cycles (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (perf_cycles)
  );

  perf_counter #(.W(CNT_W)) u_stalls (
    .clk   (clk),
    .rst   (rst),
    .en    (is_stall(mode)),
    .count (perf_stalls)
  );

  perf_counter #(.W(CNT_W)) u_flushes (
    .clk   (clk),
    .rst   (rst),
    .en    (mode == REDIRECT),
    .count (perf_flushes)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl. The driver applies one input
// vector per cycle shortly after the rising edge and pushes the expected
// outputs for that cycle; the monitor pops and compares on the falling edge.
module tb_pipe_ctrl;

  localparam int CNT_W     = 8;
  localparam int MAX_STALL = 3;
  localparam int CNT_MASK  = (1 << CNT_W) - 1;
  localparam int EXP_W     = 9 + 3 * CNT_W;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hz_stall = 1'b0, br_taken = 1'b0, imem_wait = 1'b0, dmem_wait = 1'b0;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;
  logic redirect_pend, hz_timeout;
  logic [CNT_W-1:0] perf_cycles, perf_stalls, perf_flushes;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk           (clk),
    .rst           (rst),
    .hz_stall      (hz_stall),
    .br_taken      (br_taken),
    .imem_wait     (imem_wait),
    .dmem_wait     (dmem_wait),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .ifid_flush    (ifid_flush),
    .idex_en       (idex_en),
    .idex_bubble   (idex_bubble),
    .exmem_en      (exmem_en),
    .memwb_en      (memwb_en),
    .redirect_pend (redirect_pend),
    .hz_timeout    (hz_timeout),
    .perf_cycles   (perf_cycles),
    .perf_stalls   (perf_stalls),
    .perf_flushes  (perf_flushes)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [EXP_W-1:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Reference model: what each pipeline stage must do, by priority of causes
  // ---------------------------------------------------------------------------
  int m_pend, m_run_hz, m_tmo, m_cyc, m_stl, m_fl;

  // Control word order: pc_en ifid_en ifid_flush idex_en idex_bubble exmem_en memwb_en
  function automatic logic [EXP_W-1:0] pack(input logic [6:0] ctrl);
    return {ctrl, m_pend[0], m_tmo[0], CNT_W'(m_cyc), CNT_W'(m_stl), CNT_W'(m_fl)};
  endfunction

  task automatic model_cycle(input logic r, h, b, i, d);
    logic [6:0] ctrl;
    bit stalled, flushed, hazard;
    if (r) begin
      m_pend = 0; m_run_hz = 0; m_tmo = 0; m_cyc = 0; m_stl = 0; m_fl = 0;
      exp_q.push_back(pack(7'b0010100));
      return;
    end
    stalled = 0; flushed = 0; hazard = 0;
    if (d) begin
      ctrl = 7'b0000000;                 // everything frozen, nothing squashed
      stalled = 1;
    end else if (b || m_pend != 0) begin
      ctrl = 7'b1111111;                 // load target, squash IF and ID
      flushed = 1;
    end else if (h) begin
      ctrl = 7'b0001111;                 // hold PC and IF/ID, bubble into EX
      stalled = 1; hazard = 1;
    end else if (i) begin
      ctrl = 7'b0111011;                 // hold PC, NOP into ID, rest advances
      stalled = 1;
    end else begin
      ctrl = 7'b1101011;                 // normal flow
    end
    exp_q.push_back(pack(ctrl));

    // State after the next rising edge
    m_cyc = (m_cyc + 1) & CNT_MASK;
    if (stalled) m_stl = (m_stl + 1) & CNT_MASK;
    if (flushed) m_fl = (m_fl + 1) & CNT_MASK;
    if (d && b) m_pend = 1;
    if (flushed) m_pend = 0;
    if (hazard) m_run_hz = m_run_hz + 1;
    else if (!d) m_run_hz = 0;
    if (m_run_hz > MAX_STALL) m_tmo = 1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, h, b, i, d);
    @(posedge clk);
    #1;
    rst = r; hz_stall = h; br_taken = b; imem_wait = i; dmem_wait = d;
    model_cycle(r, h, b, i, d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  // Reset must act without any clock edge: checked 1 ns after rst rises.
  task automatic check_reset_now();
    logic [EXP_W-1:0] got;
    logic [EXP_W-1:0] want;
    #1;
    got  = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en,
            redirect_pend, hz_timeout, perf_cycles, perf_stalls, perf_flushes};
    want = {7'b0010100, 2'b00, {(3 * CNT_W){1'b0}}};
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL async_reset at %0t: got %h expected %h", $time, got, want);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] got;
    logic [EXP_W-1:0] want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en,
              redirect_pend, hz_timeout, perf_cycles, perf_stalls, perf_flushes};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL cycle_outputs at %0t (in h=%b b=%b i=%b d=%b r=%b): ctrl/pend/tmo %b/%b/%b got, %b/%b/%b expected; cyc/stl/fl %0d/%0d/%0d got, %0d/%0d/%0d expected",
                 $time, hz_stall, br_taken, imem_wait, dmem_wait, rst,
                 got[EXP_W-1 -: 7], got[EXP_W-8], got[EXP_W-9],
                 want[EXP_W-1 -: 7], want[EXP_W-8], want[EXP_W-9],
                 got[3*CNT_W-1 -: CNT_W], got[2*CNT_W-1 -: CNT_W], got[CNT_W-1:0],
                 want[3*CNT_W-1 -: CNT_W], want[2*CNT_W-1 -: CNT_W], want[CNT_W-1:0]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int budget;
    // Power-on reset
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Reset mid-run with perf_cycles at 20
    idle(20);
    step(1, 0, 0, 0, 0);
    check_reset_now();
    step(0, 0, 0, 0, 0);

    // Three hazard cycles: no timeout
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
    idle(2);

    // Four hazard cycles: sticky timeout
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0);
    idle(3);

    // Hazard run interrupted by a freeze keeps its count
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    idle(2);

    // Branch together with hazard and fetch wait: redirect wins
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    idle(2);

    // Branch during a two-cycle freeze, repeated in the release cycle
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    idle(2);
    step(0, 0, 1, 0, 1);
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 1, 0);
    idle(2);

    // Single fetch wait in an idle stream
    step(0, 0, 0, 1, 0);
    idle(2);

    // Random traffic, long enough to wrap the 8-bit counters
    for (int k = 0; k < 700; k++) begin
      if (k == 350) step(1, 0, 0, 0, 0);
      step(0,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 20);
    end
    idle(1);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, 0 required", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
